// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing NUM_CHANNELS memory channels among NUM_CONSUMERS read/write requesters.
// Latency: request valid at edge t -> mem valid from t+1; mem ready at edge t+k -> consumer ready from t+k+1.
// Backpressure: a granted consumer holds its channel until it drops valid; only that channel stalls.
//
// Ports:
//   clk, reset                          : clock, synchronous active-high reset
//   consumer_read_valid/address         : per-consumer read requests
//   consumer_read_ready/data            : per-consumer read completion and returned data
//   consumer_write_valid/address/data   : per-consumer write requests
//   consumer_write_ready                : per-consumer write completion
//   mem_read_valid/address, mem_read_ready/data           : per-channel read interface to memory
//   mem_write_valid/address/data, mem_write_ready         : per-channel write interface to memory
module memory_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
    output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
);

    localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ_WAITING,
        ST_WRITE_WAITING,
        ST_READ_RELAYING,
        ST_WRITE_RELAYING
    } state_t;

    state_t                 r_state [NUM_CHANNELS];
    logic [IDX_W-1:0]       r_idx   [NUM_CHANNELS];
    logic [IDX_W-1:0]       r_ptr   [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] r_claim;

    logic [NUM_CONSUMERS-1:0]                r_consumer_read_ready;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] r_consumer_read_data;
    logic [NUM_CONSUMERS-1:0]                r_consumer_write_ready;
    logic [NUM_CHANNELS-1:0]                 r_mem_read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  r_mem_read_address;
    logic [NUM_CHANNELS-1:0]                 r_mem_write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  r_mem_write_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  r_mem_write_data;

    logic [NUM_CONSUMERS-1:0] w_wr_pend;
    logic [NUM_CONSUMERS-1:0] w_pend;
    logic [NUM_CONSUMERS-1:0] w_taken;
    logic [IDX_W-1:0]         w_cand;
    logic [NUM_CHANNELS-1:0]  w_grant_vld;
    logic [NUM_CHANNELS-1:0]  w_grant_rd;
    logic [IDX_W-1:0]         w_grant_idx [NUM_CHANNELS];

    // (base + offset) mod NUM_CONSUMERS; both operands are already below NUM_CONSUMERS.
    function automatic logic [IDX_W-1:0] f_wrap(input logic [IDX_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_CONSUMERS) begin
            sum = sum - NUM_CONSUMERS;
        end
        return sum[IDX_W-1:0];
    endfunction

    // Program-memory instances never see write requests at all.
    assign w_wr_pend = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;
    assign w_pend    = consumer_read_valid | w_wr_pend;

    // Channels pick in index order; w_taken accumulates claims plus this cycle's
    // earlier grants so no consumer lands on two channels.
    always_comb begin
        w_taken     = r_claim;
        w_cand      = '0;
        w_grant_vld = '0;
        w_grant_rd  = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            w_grant_idx[ch] = '0;
            if (r_state[ch] == ST_IDLE) begin
                for (int k = 0; k < NUM_CONSUMERS; k++) begin
                    w_cand = f_wrap(r_ptr[ch], k);
                    if (!w_grant_vld[ch] && w_pend[w_cand] && !w_taken[w_cand]) begin
                        w_grant_vld[ch] = 1'b1;
                        w_grant_idx[ch] = w_cand;
                        w_grant_rd[ch]  = consumer_read_valid[w_cand];
                    end
                end
                if (w_grant_vld[ch]) begin
                    w_taken[w_grant_idx[ch]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                r_state[ch] <= ST_IDLE;
                r_idx[ch]   <= '0;
                r_ptr[ch]   <= '0;
            end
            r_claim                <= '0;
            r_consumer_read_ready  <= '0;
            r_consumer_read_data   <= '0;
            r_consumer_write_ready <= '0;
            r_mem_read_valid       <= '0;
            r_mem_read_address     <= '0;
            r_mem_write_valid      <= '0;
            r_mem_write_address    <= '0;
            r_mem_write_data       <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                case (r_state[ch])
                    ST_IDLE: begin
                        if (w_grant_vld[ch]) begin
                            r_claim[w_grant_idx[ch]] <= 1'b1;
                            r_idx[ch]                <= w_grant_idx[ch];
                            r_ptr[ch]                <= f_wrap(w_grant_idx[ch], 1);
                            if (w_grant_rd[ch]) begin
                                r_state[ch]            <= ST_READ_WAITING;
                                r_mem_read_valid[ch]   <= 1'b1;
                                r_mem_read_address[ch] <= consumer_read_address[w_grant_idx[ch]];
                            end else begin
                                r_state[ch]             <= ST_WRITE_WAITING;
                                r_mem_write_valid[ch]   <= 1'b1;
                                r_mem_write_address[ch] <= consumer_write_address[w_grant_idx[ch]];
                                r_mem_write_data[ch]    <= consumer_write_data[w_grant_idx[ch]];
                            end
                        end
                    end
                    ST_READ_WAITING: begin
                        if (mem_read_ready[ch]) begin
                            r_consumer_read_data[r_idx[ch]]  <= mem_read_data[ch];
                            r_consumer_read_ready[r_idx[ch]] <= 1'b1;
                            r_mem_read_valid[ch]             <= 1'b0;
                            r_state[ch]                      <= ST_READ_RELAYING;
                        end
                    end
                    ST_WRITE_WAITING: begin
                        if (mem_write_ready[ch]) begin
                            r_consumer_write_ready[r_idx[ch]] <= 1'b1;
                            r_mem_write_valid[ch]             <= 1'b0;
                            r_state[ch]                       <= ST_WRITE_RELAYING;
                        end
                    end
                    // Claim is released only once the consumer has seen ready and dropped valid.
                    ST_READ_RELAYING: begin
                        if (!consumer_read_valid[r_idx[ch]]) begin
                            r_consumer_read_ready[r_idx[ch]] <= 1'b0;
                            r_claim[r_idx[ch]]               <= 1'b0;
                            r_state[ch]                      <= ST_IDLE;
                        end
                    end
                    ST_WRITE_RELAYING: begin
                        if (!consumer_write_valid[r_idx[ch]]) begin
                            r_consumer_write_ready[r_idx[ch]] <= 1'b0;
                            r_claim[r_idx[ch]]                <= 1'b0;
                            r_state[ch]                       <= ST_IDLE;
                        end
                    end
                    default: r_state[ch] <= ST_IDLE;
                endcase
            end
        end
    end

    assign consumer_read_ready  = r_consumer_read_ready;
    assign consumer_read_data   = r_consumer_read_data;
    assign consumer_write_ready = r_consumer_write_ready;
    assign mem_read_valid       = r_mem_read_valid;
    assign mem_read_address     = r_mem_read_address;
    assign mem_write_valid      = r_mem_write_valid;
    assign mem_write_address    = r_mem_write_address;
    assign mem_write_data       = r_mem_write_data;

endmodule
